// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle RV32 subset core: opcodes, ALU codes,
// control states and immediate formats.
package mc_cpu_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B} imm_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_t sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared with the single-cycle core.
module alu
  import mc_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SUB: result = a - b;
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mc_control_fsm.sv
// Control FSM for the multi-cycle core: sequences FETCH/DECODE/EXEC/MEM/WB
// and decodes the per-state datapath controls from the instruction fields.
module mc_control_fsm
  import mc_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_b,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       alu_zero,
  input  logic       alu_neg,
  output logic       ir_we,
  output logic       decode_we,
  output logic       aluout_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       alu_src,
  output logic [3:0] alu_op,
  output imm_t       imm_sel,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       imem_req,
  output logic       retire,
  output logic       halted
);

  state_t state_q, state_d;
  logic   legal;
  logic   taken;
  logic [3:0] exec_op;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= FETCH;
    else          state_q <= state_d;
  end

  assign legal = (opcode == OP_LOAD)  || (opcode == OP_STORE) || (opcode == OP_RTYPE) ||
                 (opcode == OP_ITYPE) || (opcode == OP_BRANCH);

  // Unsupported funct3 values fall back to add / beq.
  always_comb begin
    exec_op = ALU_ADD;
    if (opcode == OP_BRANCH) begin
      exec_op = ALU_SUB;
    end else if (opcode == OP_RTYPE || opcode == OP_ITYPE) begin
      case (funct3)
        3'b000:  exec_op = (opcode == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b100:  exec_op = ALU_XOR;
        3'b110:  exec_op = ALU_OR;
        3'b111:  exec_op = ALU_AND;
        default: exec_op = ALU_ADD;
      endcase
    end
  end

  // blt/bge look only at the sign of A-B, without overflow correction.
  always_comb begin
    case (funct3)
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_neg;
      3'b101:  taken = !alu_neg;
      default: taken = alu_zero;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_we     = 1'b0;
    decode_we = 1'b0;
    aluout_we = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    alu_src   = 1'b0;
    alu_op    = exec_op;
    imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    imem_req  = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = reset_b;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        decode_we = 1'b1;
        state_d   = legal ? EXEC : HALT;
      end
      EXEC: begin
        aluout_we = 1'b1;
        if (opcode == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = taken;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          alu_src = 1'b1;
          state_d = MEM;
        end else begin
          alu_src = (opcode == OP_ITYPE);
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_we  = 1'b1;
        wb_sel  = (opcode == OP_LOAD);
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// 32-entry register file, two combinational read ports, x0 hardwired to zero.
module regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data
);

  logic [WIDTH-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (we && rd_addr != 5'd0) mem[rd_addr] <= wdata;
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : mem[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : mem[rs2_addr];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV32 subset core with valid/ready instruction and data ports,
// illegal-opcode halt and a retired-instruction counter.
module multi_cycle_cpu
  import mc_cpu_pkg::*;
#(
  parameter int              REG_WIDTH       = 32,
  parameter int              IMEM_ADDR_WIDTH = 10,
  parameter int              DMEM_ADDR_WIDTH = 10,
  parameter logic [31:0]     RESET_PC        = 32'h0,
  parameter int              INSTRET_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset_b,
  output logic                       imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ready,
  input  logic [31:0]                imem_rdata,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]                dmem_wdata,
  input  logic                       dmem_ready,
  input  logic [31:0]                dmem_rdata,
  output logic                       halted,
  output logic [INSTRET_WIDTH-1:0]   instret
);

  logic [REG_WIDTH-1:0]     pc_q, pc_d;
  logic [31:0]              ir_q, ir_d;
  logic [REG_WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [REG_WIDTH-1:0]     target_q, target_d;
  logic [REG_WIDTH-1:0]     aluout_q, aluout_d;
  logic [REG_WIDTH-1:0]     mdr_q, mdr_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

  logic       ir_we, decode_we, aluout_we, mdr_we, pc_we, pc_src;
  logic       reg_we, wb_sel, alu_src, retire, alu_zero;
  logic [3:0] alu_op;
  imm_t       imm_sel;

  logic [REG_WIDTH-1:0] rs1_data, rs2_data, alu_b, alu_result, imm, wb_data;

  mc_control_fsm u_fsm (
    .clk        (clk),
    .reset_b    (reset_b),
    .opcode     (ir_q[6:0]),
    .funct3     (ir_q[14:12]),
    .funct7_5   (ir_q[30]),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_result[REG_WIDTH-1]),
    .ir_we      (ir_we),
    .decode_we  (decode_we),
    .aluout_we  (aluout_we),
    .mdr_we     (mdr_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .imm_sel    (imm_sel),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .imem_req   (imem_req),
    .retire     (retire),
    .halted     (halted)
  );

  regfile #(.WIDTH(REG_WIDTH)) u_regfile (
    .clk      (clk),
    .rs1_addr (ir_q[19:15]),
    .rs2_addr (ir_q[24:20]),
    .rd_addr  (ir_q[11:7]),
    .we       (reg_we),
    .wdata    (wb_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  assign imm   = imm_gen(ir_q, imm_sel);
  assign alu_b = alu_src ? imm : b_q;

  alu #(.WIDTH(REG_WIDTH)) u_alu (
    .a           (a_q),
    .b           (alu_b),
    .alu_control (alu_op),
    .result      (alu_result),
    .zero        (alu_zero)
  );

  assign wb_data = wb_sel ? mdr_q : aluout_q;

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    target_d  = target_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    instret_d = instret_q;
    if (ir_we) ir_d = imem_rdata;
    // Branch target is formed from the branch's own pc before pc advances.
    if (decode_we) begin
      a_d      = rs1_data;
      b_d      = rs2_data;
      target_d = pc_q + imm_gen(ir_q, IMM_B);
    end
    if (aluout_we) aluout_d = alu_result;
    if (mdr_we)    mdr_d    = dmem_rdata;
    if (pc_we)     pc_d     = pc_src ? target_q : pc_q + 32'd4;
    if (retire)    instret_d = instret_q + INSTRET_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      target_q  <= '0;
      aluout_q  <= '0;
      mdr_q     <= '0;
      instret_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      target_q  <= target_d;
      aluout_q  <= aluout_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
    end
  end

  assign imem_addr  = pc_q[IMEM_ADDR_WIDTH+1:2];
  assign dmem_addr  = aluout_q[DMEM_ADDR_WIDTH+1:2];
  assign dmem_wdata = b_q;
  assign instret    = instret_q;

endmodule

// File: doc/multi_cycle_cpu.md
Name: multi_cycle_cpu

Overview:
- Multi-cycle RV32 subset CPU. Next generation of the team's single-cycle core.
- Instruction and data memories are external and reached over valid/ready request ports, so memories with any wait-state count can be attached.
- A control FSM sequences FETCH/DECODE/EXEC/MEM/WB. The PC, address width and reset vector are parametrised.
- Adds an illegal-opcode halt and a retired-instruction counter.

Parameters:
- REG_WIDTH, 32, datapath width; only 32 is supported.
- IMEM_ADDR_WIDTH, 10, word-address width of imem_addr.
- DMEM_ADDR_WIDTH, 10, word-address width of dmem_addr.
- RESET_PC, 32'h0, byte address loaded into the PC on reset.
- INSTRET_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  IMEM_ADDR_WIDTH  word address, equal to pc[IMEM_ADDR_WIDTH+1:2].
- imem_ready  in  1  imem_rdata valid; completes the fetch.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  DMEM_ADDR_WIDTH  alu_out[DMEM_ADDR_WIDTH+1:2].
- dmem_wdata  out  32  store data (rs2).
- dmem_ready  in  1  access complete; dmem_rdata valid for loads.
- dmem_rdata  in  32  load data.
- halted  out  1  sticky; set on an illegal opcode.
- instret  out  INSTRET_WIDTH  count of retired instructions.

Behaviour:
- Reset (reset_b low, async):
  - state=FETCH, pc=RESET_PC.
  - imem_req=0, dmem_req=0, dmem_we=0, halted=0, instret=0; IR, A, B and ALUOut registers are cleared.
  - Reset may be asserted mid-access; any outstanding request is abandoned. The first cycle after release asserts imem_req.
- ISA:
  - lw (0000011), sw (0100011). funct3 is ignored; word access only.
  - R-type (0110011): add, sub, xor, or, and.
  - I-type ALU (0010011): addi, xori, ori, andi.
  - Branches (1100011): beq, bne, blt, bge.
  - Any other opcode goes to HALT.
  - Unsupported funct3 within a legal opcode executes as add (or beq for branches).
- ALU control codes: and 0000, or 0001, add 0010, xor 0011, sub 0110.
  - Branches use sub. blt/bge test the sign bit of the difference only; no overflow correction.
- Immediates:
  - I, S and B formats are sign-extended to 32 bits.
  - The B immediate is shifted left by 1.
  - Branch target = pc + immB, where pc is the address of the branch itself.
- FETCH:
  - imem_req=1, with imem_addr stable while req && !ready.
  - On imem_ready: IR<=imem_rdata, go to DECODE. imem_req drops the next cycle.
- DECODE:
  - A<=rs1, B<=rs2, target<=pc+immB.
  - Illegal opcode -> HALT. Otherwise -> EXEC.
- EXEC:
  - ALUOut<=A op (B or imm).
  - Branch: pc<=taken ? target : pc+4; instret++; -> FETCH.
  - lw/sw -> MEM. ALU op -> WB.
- MEM:
  - dmem_req=1 and dmem_we=(sw); address and wdata are held stable until dmem_ready.
  - On ready, sw: pc<=pc+4, instret++, -> FETCH.
  - On ready, lw: MDR<=dmem_rdata, -> WB.
- WB:
  - rd<=(lw ? MDR : ALUOut); the write is suppressed when rd==0.
  - pc<=pc+4, instret++, -> FETCH.
- HALT:
  - Terminal state; halted=1; all requests low; pc and instret frozen.
  - Only reset exits HALT.
- Zero-wait-state cycle counts: branch 3, sw 4, ALU 4, lw 5. Each wait cycle on a port adds one cycle.
- Width and wrap rules:
  - pc+4 wraps modulo 2^32. instret wraps to 0 after its maximum value.
  - Address bits above the port widths are ignored; memory aliases.
- At most one request is asserted at a time. imem_req and dmem_req are never high together.

Decomposition:
- Package mc_cpu_pkg holds:
  - opcode constants;
  - the 4-bit alu_control codes;
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - the immediate-type enum.
- Sub-module mc_control_fsm: state register plus next-state and control decode. It outputs ir_we, pc_we, pc_src, reg_we, wb_sel, alu_src, alu_op, dmem_req, dmem_we, imem_req, retire.
- The datapath reuses the existing regfile and alu modules.

Test Plan:
- Zero-wait memories, program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 -> x3=12, instret=3 after 12 cycles.
- imem_ready held low 3 cycles on the first fetch -> imem_addr stable at 0 throughout, IR loads only on ready, addi latency is 7.
- sw x3,8(x0) then lw x4,8(x0), with dmem_ready delayed 2 cycles -> dmem_addr=2, dmem_wdata=12, dmem_we=1 then 0, x4=12.
- beq x1,x1,-8 at pc=0x10 -> next fetch at 0x08. bne x1,x1 at the same pc -> 0x14. blt with x1=-1, x2=1 -> taken.
- Opcode 7'b1111111 -> halted=1 one cycle after DECODE; no further imem_req; instret unchanged.
- reset_b pulsed low while dmem_req=1 -> dmem_req=0 immediately, pc=RESET_PC, fetch restarts at 0. addi x0,x0,9 -> x0 reads 0.
